// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage and its instruction buffer.
package fetch_stage_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Force an address onto a word boundary.
  function automatic addr_t word_align(input addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_inst_fifo.sv
// Instruction buffer: circular FIFO of {instruction, PC} pairs with push, pop
// and a flush that discards everything (including a same-cycle push).
module inst_fifo
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  inst_t            push_inst,
  input  addr_t            push_pc,
  input  logic             pop,
  input  logic             flush,
  output inst_t            head_inst,
  output addr_t            head_pc,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  inst_t            inst_mem [DEPTH];
  addr_t            pc_mem   [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0) && !flush;
    do_push  = push && (!full || do_pop) && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are DEPTH-sized (power of two), so they wrap naturally.
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      inst_mem[wr_ptr_q] <= push_inst;
      pc_mem[wr_ptr_q]   <= push_pc;
    end
  end

  // Head of the queue and its occupancy.
  always_comb begin
    head_inst = inst_mem[rd_ptr_q];
    head_pc   = pc_mem[rd_ptr_q];
    count     = count_q;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential word reads to the instruction
// SRAM, buffers returned words with their PCs, and presents them to decode
// with a valid/ready handshake. A redirect flushes everything in flight.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        ds_ready,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  addr_t            fpc_q, fpc_d;
  addr_t            req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             discard_q, discard_d;

  logic [CNT_W-1:0] count;
  inst_t            head_inst;
  addr_t            head_pc;
  logic             issue;
  logic             pop;
  logic             push;
  logic             flush;
  logic             valid_int;
  logic [CNT_W:0]   occupancy;

  // Handshake, request issue and buffer write decisions.
  always_comb begin
    valid_int = !reset && (count != '0);
    pop       = valid_int && ds_ready;
    // Entries held plus the one possibly arriving, minus the one leaving now.
    occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    issue     = !reset && !br_valid && (occupancy < (CNT_W+1)'(BUF_DEPTH));
    flush     = br_valid;
    // A response belonging to the pre-redirect path never reaches the buffer.
    push      = inflight_q && !discard_q && !br_valid && !reset;
  end

  // Next-state for fetch PC and the outstanding-request tracking.
  always_comb begin
    fpc_d      = fpc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    discard_d  = br_valid;
    if (br_valid) begin
      fpc_d = word_align(br_target);
    end else if (issue) begin
      fpc_d = fpc_q + 32'd4;
    end
    if (issue) req_pc_d = fpc_q;
  end

  // Fetch-side state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q      <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  inst_fifo #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_inst_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_inst (inst_sram_rdata),
    .push_pc   (req_pc_q),
    .pop       (pop),
    .flush     (flush),
    .head_inst (head_inst),
    .head_pc   (head_pc),
    .count     (count)
  );

  // SRAM request and decode-facing outputs; zeroed while nothing is valid.
  always_comb begin
    inst_sram_en    = issue;
    inst_sram_we    = 1'b0;
    inst_sram_addr  = fpc_q;
    inst_sram_wdata = '0;
    fs_valid        = valid_int;
    fs_pc           = valid_int ? head_pc : '0;
    fs_inst         = valid_int ? head_inst : '0;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run checked against an in-order program-counter scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = '0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        ds_ready = 1'b0;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .br_valid        (br_valid),
    .br_target       (br_target),
    .ds_ready        (ds_ready),
    .fs_valid        (fs_valid),
    .fs_pc           (fs_pc),
    .fs_inst         (fs_inst)
  );

  // Program image: word i past RST_PC holds 0x1000 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_1000 + ((a - RST_PC) >> 2);
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
  end

  // Drive one cycle of inputs mid-cycle and let outputs settle.
  task automatic cycle(input logic rst, input logic br, input logic [31:0] tgt,
                       input logic rdy);
    @(negedge clk);
    reset = rst; br_valid = br; br_target = tgt; ds_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (inst_sram_en !== 1'b0) $display("FAIL reset_en: got %b want 0", inst_sram_en); else passed++;
      checks++; if (fs_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", fs_valid); else passed++;
      checks++; if (fs_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", fs_pc); else passed++;
      checks++; if (fs_inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", fs_inst); else passed++;
    end
    checks++; if (inst_sram_we !== 1'b0) $display("FAIL we_tied: got %b want 0", inst_sram_we); else passed++;
    checks++; if (inst_sram_wdata !== 32'h0) $display("FAIL wdata_tied: got %h want 0", inst_sram_wdata); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (inst_sram_en !== 1'b1) $display("FAIL stream_en c%0d: got %b want 1", c, inst_sram_en); else passed++;
      checks++; if (inst_sram_addr !== RST_PC + 32'(4 * c)) $display("FAIL stream_addr c%0d: got %h want %h", c, inst_sram_addr, RST_PC + 32'(4 * c)); else passed++;
      if (c < 2) begin
        checks++; if (fs_valid !== 1'b0) $display("FAIL stream_latency c%0d: got %b want 0", c, fs_valid); else passed++;
      end else begin
        checks++; if (fs_valid !== 1'b1) $display("FAIL stream_valid c%0d: got %b want 1", c, fs_valid); else passed++;
        checks++; if (fs_pc !== RST_PC + 32'(4 * (c - 2))) $display("FAIL stream_pc c%0d: got %h want %h", c, fs_pc, RST_PC + 32'(4 * (c - 2))); else passed++;
        checks++; if (fs_inst !== 32'h1000 + 32'(c - 2)) $display("FAIL stream_inst c%0d: got %h want %h", c, fs_inst, 32'h1000 + 32'(c - 2)); else passed++;
      end
    end
  endtask

  task automatic test_stall();
    int reqs = 0;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1); reqs += int'(inst_sram_en);
    cycle(1'b0, 1'b0, 32'h0, 1'b1); reqs += int'(inst_sram_en);
    for (int c = 2; c < 7; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0); reqs += int'(inst_sram_en);
      checks++; if (fs_valid !== 1'b1) $display("FAIL stall_valid c%0d: got %b want 1", c, fs_valid); else passed++;
      checks++; if (fs_inst !== 32'h1000) $display("FAIL stall_hold c%0d: got %h want 00001000", c, fs_inst); else passed++;
    end
    checks++; if (reqs != 2) $display("FAIL stall_reqs: got %0d want 2", reqs); else passed++;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (fs_valid !== 1'b1) $display("FAIL resume_valid k%0d: got %b want 1", k, fs_valid); else passed++;
      checks++; if (fs_pc !== RST_PC + 32'(4 * k)) $display("FAIL resume_pc k%0d: got %h want %h", k, fs_pc, RST_PC + 32'(4 * k)); else passed++;
      checks++; if (fs_inst !== 32'h1000 + 32'(k)) $display("FAIL resume_inst k%0d: got %h want %h", k, fs_inst, 32'h1000 + 32'(k)); else passed++;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    // Cycle 3: redirect while a request is in flight and a handshake completes.
    cycle(1'b0, 1'b1, 32'h1c00_0103, 1'b1);
    checks++; if (fs_pc !== RST_PC + 32'd4) $display("FAIL redir_accept_pc: got %h want %h", fs_pc, RST_PC + 32'd4); else passed++;
    checks++; if (inst_sram_en !== 1'b0) $display("FAIL redir_suppress: got %b want 0", inst_sram_en); else passed++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (fs_valid !== 1'b0) $display("FAIL redir_empty: got %b want 0", fs_valid); else passed++;
    checks++; if (inst_sram_en !== 1'b1) $display("FAIL redir_req_en: got %b want 1", inst_sram_en); else passed++;
    checks++; if (inst_sram_addr !== 32'h1c00_0100) $display("FAIL redir_req_addr: got %h want 1c000100", inst_sram_addr); else passed++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (fs_valid !== 1'b0) $display("FAIL redir_stale: got %b want 0", fs_valid); else passed++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (fs_valid !== 1'b1) $display("FAIL redir_valid: got %b want 1", fs_valid); else passed++;
    checks++; if (fs_pc !== 32'h1c00_0100) $display("FAIL redir_pc: got %h want 1c000100", fs_pc); else passed++;
    checks++; if (fs_inst !== mem_word(32'h1c00_0100)) $display("FAIL redir_inst: got %h want %h", fs_inst, mem_word(32'h1c00_0100)); else passed++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (fs_pc !== 32'h1c00_0104) $display("FAIL redir_next_pc: got %h want 1c000104", fs_pc); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h1c00_0200, 1'b1);
    checks++; if (inst_sram_en !== 1'b0) $display("FAIL b2b_first_en: got %b want 0", inst_sram_en); else passed++;
    cycle(1'b0, 1'b1, 32'h1c00_0301, 1'b1);
    checks++; if (inst_sram_en !== 1'b0) $display("FAIL b2b_second_en: got %b want 0", inst_sram_en); else passed++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_sram_addr !== 32'h1c00_0300 || inst_sram_en !== 1'b1) $display("FAIL b2b_req: got en %b addr %h want en 1 addr 1c000300", inst_sram_en, inst_sram_addr); else passed++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (fs_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", fs_valid); else passed++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (fs_pc !== 32'h1c00_0300 || fs_valid !== 1'b1) $display("FAIL b2b_pc: got valid %b pc %h want valid 1 pc 1c000300", fs_valid, fs_pc); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (fs_valid !== 1'b0) $display("FAIL midrst_valid %0d: got %b want 0", i, fs_valid); else passed++;
      checks++; if (inst_sram_en !== 1'b0) $display("FAIL midrst_en %0d: got %b want 0", i, inst_sram_en); else passed++;
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST_PC) $display("FAIL midrst_req: got en %b addr %h want en 1 addr %h", inst_sram_en, inst_sram_addr, RST_PC); else passed++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (fs_valid !== 1'b0) $display("FAIL midrst_drop: got %b want 0", fs_valid); else passed++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (fs_valid !== 1'b1 || fs_pc !== RST_PC || fs_inst !== 32'h1000) $display("FAIL midrst_restart: got valid %b pc %h inst %h want 1 %h 00001000", fs_valid, fs_pc, fs_inst, RST_PC); else passed++;
  endtask

  // Scoreboard: accepted PCs must be the sequential stream from the last
  // reset/redirect, each exactly once, with matching memory contents.
  task automatic test_random();
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] prev_pc = '0;
    logic        prev_hold = 1'b0;
    int          accepts = 0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      logic        br  = ($urandom_range(0, 19) == 0);
      logic        rdy = ($urandom_range(0, 3) != 0);
      logic [31:0] tgt = RST_PC + $urandom_range(0, 32'h3fff);
      cycle(1'b0, br, tgt, rdy);
      if (br) begin
        checks++; if (inst_sram_en !== 1'b0) $display("FAIL rnd_br_en c%0d: got %b want 0", c, inst_sram_en); else passed++;
      end
      if (prev_hold) begin
        checks++; if (fs_valid !== 1'b1 || fs_pc !== prev_pc) $display("FAIL rnd_hold c%0d: got valid %b pc %h want 1 %h", c, fs_valid, fs_pc, prev_pc); else passed++;
      end
      if (fs_valid && rdy) begin
        checks++; if (fs_pc !== exp_pc) $display("FAIL rnd_pc c%0d: got %h want %h", c, fs_pc, exp_pc); else passed++;
        checks++; if (fs_inst !== mem_word(fs_pc)) $display("FAIL rnd_inst c%0d: got %h want %h", c, fs_inst, mem_word(fs_pc)); else passed++;
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
      if (br) exp_pc = tgt & ~32'h3;
      prev_hold = fs_valid && !rdy && !br;
      prev_pc   = fs_pc;
    end
    checks++; if (accepts < 2000) $display("FAIL rnd_progress: got %0d accepts want >= 2000", accepts); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h1c000000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inst_sram_en  out  1  read request this cycle.
REQ-006 inst_sram_we  out  1  tied 0.
REQ-007 inst_sram_addr  out  32  word-aligned fetch address.
REQ-008 inst_sram_wdata  out  32  tied 0.
REQ-009 inst_sram_rdata  in  32  read data, valid the cycle after an accepted request.
REQ-010 br_valid  in  1  redirect strobe from execute.
REQ-011 br_target  in  32  redirect address; bits [1:0] ignored.
REQ-012 ds_ready  in  1  decode accepts an instruction.
REQ-013 fs_valid  out  1  fs_pc/fs_inst hold a valid instruction.
REQ-014 fs_pc  out  32  PC of presented instruction.
REQ-015 fs_inst  out  32  instruction word.

Function
REQ-016 Fetch PC register (fpc) SHALL advance by 4 on every issued request; no other increment.
REQ-017 Request SHALL issue (inst_sram_en=1, addr=fpc) when count + inflight - pop < BUF_DEPTH and br_valid=0, where pop = fs_valid & ds_ready.
REQ-018 inflight SHALL be a 1-bit flag set by an issued request, cleared the following cycle.
REQ-019 When inflight=1 and no flush is pending, inst_sram_rdata SHALL be written with its PC into the FIFO tail that cycle.
REQ-020 Latency SHALL be 2 cycles: request in cycle N, fs_valid in N+2; no bypass path.
REQ-021 With ds_ready held 1, throughput SHALL be one instruction per cycle.
REQ-022 fs_valid=1 iff count>0; fs_pc/fs_inst SHALL be the FIFO head and stay stable while fs_valid & !ds_ready.
REQ-023 Handshake completes on fs_valid & ds_ready; head pops at that edge.
REQ-024 br_valid=1 SHALL: empty the FIFO, set fpc to {br_target[31:2],2'b00}, suppress any request that cycle, and mark an inflight response for discard.
REQ-025 Discarded response SHALL NOT enter the FIFO; first request at the target issues the cycle after br_valid.
REQ-026 Simultaneous br_valid and fs_valid&ds_ready: handshake counts as accepted; redirect flush takes priority over all other FIFO writes.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo BUF_DEPTH.
REQ-028 Back-to-back br_valid on consecutive cycles: last target wins, no request between them.

Reset
REQ-029 On reset=1: fpc=RESET_PC, count=0, pointers=0, inflight=0, discard=0.
REQ-030 During reset outputs SHALL be inst_sram_en=0, fs_valid=0, fs_pc=0, fs_inst=0.
REQ-031 Reset asserted mid-fetch SHALL drop any inflight response; first request issues the first cycle reset is low.

Structure
REQ-032 RESET_PC default and the instruction word width SHALL live in the shared cpu package.
REQ-033 The FIFO SHALL be one sub-module, inst_fifo (data+PC, push/pop/flush, count).

Verification
REQ-034 Reset release, ds_ready=1, memory word i = 32'h0000_1000+i -> fs_pc 1c000000,1c000004,... one per cycle from cycle 2, fs_inst matching.
REQ-035 ds_ready=0 for 5 cycles after first valid -> fs_inst held at 32'h00001000, exactly 2 requests issued, none lost after ds_ready=1.
REQ-036 br_valid with target 32'h1c000103 while a request is inflight -> next fs_pc 1c000100; stale fpc data never presented.
REQ-037 br_valid coincident with handshake -> accepted instruction counted once, FIFO empty next cycle, fs_valid 2 cycles after first target request.
REQ-038 Reset pulse at cycle 3 of streaming -> fs_valid=0 during reset, stream restarts at 1c000000.
REQ-039 Random ds_ready and br_valid, 10k cycles -> scoreboard: presented PCs follow sequential/redirect order, no duplicates, no drops.
